// File: rtl/req_encoder_rr_pkg.sv
// Shared constants for the request encoder / arbiter family.
// FSM encodings are plain constants so older blocks can reuse them.
package req_encoder_rr_pkg;

    localparam int N_DEF     = 16;
    localparam int IDX_W_DEF = 4;

    // Same base one-hot the 4-to-16 decoder shifts by its index.
    localparam logic [N_DEF-1:0] ONE_HOT_LSB = 16'h0001;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

endpackage

// File: rtl/req_encoder_rr_if.sv
// Request/grant bundle between event sources, encoder and consumer.
// master drives requests and acknowledge; slave is the encoder.
interface req_encoder_rr_if
    import req_encoder_rr_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int IDX_W = IDX_W_DEF
);

    logic [N-1:0]     IN;
    logic [IDX_W-1:0] OUT;
    logic             VALID;
    logic             ACK;
    logic [N-1:0]     PENDING;

    modport master (
        output IN,
        output ACK,
        input  OUT,
        input  VALID,
        input  PENDING
    );

    modport slave (
        input  IN,
        input  ACK,
        output OUT,
        output VALID,
        output PENDING
    );

endinterface

// File: rtl/req_encoder_rr_pick.sv
// Combinational rotating-priority picker: first set bit at or after ptr.
// mode=0 forces the scan base to 0, giving lowest-index-wins.
module rr_pick
    import req_encoder_rr_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] base;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    assign base = mode ? ptr : '0;
    assign dbl  = {mask, mask} >> base;
    assign rot  = dbl[N-1:0];
    assign any  = |mask;

    // Lowest set bit of the rotated mask is the offset from base.
    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
    end

    assign sum = {1'b0, base} + {1'b0, off};
    assign idx = (sum >= (IDX_W+1)'(N))
               ? IDX_W'(sum - (IDX_W+1)'(N))
               : sum[IDX_W-1:0];

endmodule

// File: rtl/req_encoder_rr.sv
// Sticky request latch plus single-grant arbiter with VALID/ACK output.
// Returns the index of one pending request; the bit clears on ACK.
module req_encoder_rr
    import req_encoder_rr_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int ROUND_ROBIN = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    req_encoder_rr_if.slave  bus
);

    if (IDX_W != $clog2(N)) begin : g_bad_width
        $error("req_encoder_rr: IDX_W must equal clog2(N)");
    end

    localparam logic [N-1:0] ONE = N'(ONE_HOT_LSB);
    localparam logic         RR  = (ROUND_ROBIN != 0);

    logic [0:0]       state;
    logic [N-1:0]     pend;
    logic [IDX_W-1:0] out_q;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W:0]   inc;
    logic             fire;
    logic [N-1:0]     clr_mask;
    logic [N-1:0]     pend_nxt;
    logic [N-1:0]     sel_mask;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    assign fire     = (state == GRANT) && bus.ACK;
    assign clr_mask = fire ? (ONE << out_q) : '0;
    // A same-cycle request re-sets a bit being cleared.
    assign pend_nxt = (pend & ~clr_mask) | bus.IN;
    // On ACK the follow-on grant sees the cleared bit and new requests.
    assign sel_mask = fire ? pend_nxt : pend;

    assign inc     = {1'b0, out_q} + (IDX_W+1)'(1);
    assign ptr_nxt = (fire && RR)
                   ? ((inc == (IDX_W+1)'(N)) ? '0 : inc[IDX_W-1:0])
                   : ptr;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .mask (sel_mask),
        .ptr  (ptr_nxt),
        .mode (RR),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign bus.OUT     = out_q;
    assign bus.VALID   = (state == GRANT);
    assign bus.PENDING = pend;

    // Pending latch, rotation pointer and IDLE/GRANT handshake FSM.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pend  <= '0;
            out_q <= '0;
            ptr   <= '0;
            state <= IDLE;
        end else begin
            pend <= pend_nxt;
            ptr  <= ptr_nxt;
            unique case (1'b1)
                (state == IDLE): begin
                    if (pick_any) begin
                        out_q <= pick_idx;
                        state <= GRANT;
                    end
                end
                (state == GRANT): begin
                    if (bus.ACK) begin
                        if (pick_any) out_q <= pick_idx;
                        else          state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_encoder_rr.sv
// Bench for req_encoder_rr: directed tables for both arbitration modes,
// then random traffic checked against a queue-free behavioural model.
module tb_req_encoder_rr;

    logic CLK = 1'b0;
    logic RST_N;

    always #5 CLK = ~CLK;

    req_encoder_rr_if #(.N(16), .IDX_W(4)) bus_rr ();
    req_encoder_rr_if #(.N(16), .IDX_W(4)) bus_fx ();

    req_encoder_rr #(.N(16), .IDX_W(4), .ROUND_ROBIN(1)) dut_rr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus_rr)
    );

    req_encoder_rr #(.N(16), .IDX_W(4), .ROUND_ROBIN(0)) dut_fx (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus_fx)
    );

    typedef struct {
        bit        rst_n;
        bit [15:0] in;
        bit        ack;
        bit        v;
        bit [3:0]  o;
        bit [15:0] p;
    } vec_t;

    vec_t rr_tab[$];
    vec_t fx_tab[$];

    int n_chk  = 0;
    int n_fail = 0;

    bit [15:0] m_pend[2];
    bit        m_vld[2];
    int        m_out[2];
    int        m_ptr[2];
    bit        synced = 1'b0;

    function automatic vec_t mk(bit r, bit [15:0] i, bit a,
                                bit v, bit [3:0] o, bit [15:0] p);
        vec_t t;
        t.rst_n = r; t.in = i; t.ack = a;
        t.v = v; t.o = o; t.p = p;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Instance 0 rotates from its pointer, instance 1 is lowest-first.
    function automatic int pick(int m, bit [15:0] p);
        int j;
        for (int k = 0; k < 16; k++) begin
            j = (m == 0) ? (m_ptr[m] + k) % 16 : k;
            if (p[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(int m, bit rst_n, bit [15:0] in, bit ack);
        bit [15:0] np;
        int s;
        if (!rst_n) begin
            m_pend[m] = '0; m_vld[m] = 1'b0;
            m_out[m] = 0; m_ptr[m] = 0;
            return;
        end
        np = m_pend[m];
        if (m_vld[m] && ack) np[m_out[m]] = 1'b0;
        np = np | in;
        if (!m_vld[m]) begin
            s = pick(m, m_pend[m]);
            if (s >= 0) begin
                m_out[m] = s;
                m_vld[m] = 1'b1;
            end
        end else if (ack) begin
            if (m == 0) m_ptr[m] = (m_out[m] + 1) % 16;
            s = pick(m, np);
            if (s >= 0) m_out[m] = s;
            else        m_vld[m] = 1'b0;
        end
        m_pend[m] = np;
    endtask

    task automatic step(bit r, bit [15:0] i0, bit a0,
                        bit [15:0] i1, bit a1);
        RST_N = r;
        bus_rr.IN = i0; bus_rr.ACK = a0;
        bus_fx.IN = i1; bus_fx.ACK = a1;
        @(posedge CLK);
        model_step(0, r, i0, a0);
        model_step(1, r, i1, a1);
        if (!r) synced = 1'b1;
        #1;
        if (synced) begin
            chk("rr_model_valid", 32'(bus_rr.VALID), 32'(m_vld[0]));
            chk("rr_model_pend", 32'(bus_rr.PENDING), 32'(m_pend[0]));
            if (m_vld[0])
                chk("rr_model_out", 32'(bus_rr.OUT), 32'(m_out[0]));
            chk("fx_model_valid", 32'(bus_fx.VALID), 32'(m_vld[1]));
            chk("fx_model_pend", 32'(bus_fx.PENDING), 32'(m_pend[1]));
            if (m_vld[1])
                chk("fx_model_out", 32'(bus_fx.OUT), 32'(m_out[1]));
        end
        @(negedge CLK);
    endtask

    task automatic run_tab(int m, vec_t t);
        if (m == 0) step(t.rst_n, t.in, t.ack, 16'h0, 1'b0);
        else        step(t.rst_n, 16'h0, 1'b0, t.in, t.ack);
        if (m == 0) begin
            chk("rr_tab_valid", 32'(bus_rr.VALID), 32'(t.v));
            chk("rr_tab_pend", 32'(bus_rr.PENDING), 32'(t.p));
            if (t.v || !t.rst_n)
                chk("rr_tab_out", 32'(bus_rr.OUT), 32'(t.o));
        end else begin
            chk("fx_tab_valid", 32'(bus_fx.VALID), 32'(t.v));
            chk("fx_tab_pend", 32'(bus_fx.PENDING), 32'(t.p));
            if (t.v || !t.rst_n)
                chk("fx_tab_out", 32'(bus_fx.OUT), 32'(t.o));
        end
    endtask

    initial begin
        bit        r;
        bit [15:0] i0, i1;
        bit        a0, a1;

        RST_N = 1'b0;
        bus_rr.IN = '0; bus_rr.ACK = 1'b0;
        bus_fx.IN = '0; bus_fx.ACK = 1'b0;

        // reset with all requests high, then quiet
        rr_tab.push_back(mk(0, 16'hFFFF, 0, 0, 0, 16'h0000));
        rr_tab.push_back(mk(0, 16'hFFFF, 0, 0, 0, 16'h0000));
        rr_tab.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000));
        rr_tab.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000));
        // single request, long hold, ACK
        rr_tab.push_back(mk(1, 16'h0020, 0, 0, 0, 16'h0020));
        rr_tab.push_back(mk(1, 16'h0000, 0, 1, 5, 16'h0020));
        for (int k = 0; k < 10; k++)
            rr_tab.push_back(mk(1, 16'h0000, 0, 1, 5, 16'h0020));
        rr_tab.push_back(mk(1, 16'h0000, 1, 0, 0, 16'h0000));
        // pointer now 6: bit 6 beats bit 0
        rr_tab.push_back(mk(1, 16'h0041, 0, 0, 0, 16'h0041));
        rr_tab.push_back(mk(1, 16'h0000, 0, 1, 6, 16'h0041));
        rr_tab.push_back(mk(1, 16'h0000, 1, 1, 0, 16'h0001));
        rr_tab.push_back(mk(1, 16'h0000, 1, 0, 0, 16'h0000));
        // pointer 1: 15 then 0, ACK tied high
        rr_tab.push_back(mk(1, 16'h8001, 1, 0, 0, 16'h8001));
        rr_tab.push_back(mk(1, 16'h0000, 1, 1, 15, 16'h8001));
        rr_tab.push_back(mk(1, 16'h0000, 1, 1, 0, 16'h0001));
        rr_tab.push_back(mk(1, 16'h0000, 1, 0, 0, 16'h0000));
        // grant 15 alone so the pointer wraps to 0
        rr_tab.push_back(mk(1, 16'h8000, 0, 0, 0, 16'h8000));
        rr_tab.push_back(mk(1, 16'h0000, 0, 1, 15, 16'h8000));
        rr_tab.push_back(mk(1, 16'h0000, 1, 0, 0, 16'h0000));
        // pointer 0: 0 then 15, twice
        for (int k = 0; k < 2; k++) begin
            rr_tab.push_back(mk(1, 16'h8001, 1, 0, 0, 16'h8001));
            rr_tab.push_back(mk(1, 16'h0000, 1, 1, 0, 16'h8001));
            rr_tab.push_back(mk(1, 16'h0000, 1, 1, 15, 16'h8000));
            rr_tab.push_back(mk(1, 16'h0000, 1, 0, 0, 16'h0000));
        end
        // set wins over clear on bit 3
        rr_tab.push_back(mk(1, 16'h0418, 0, 0, 0, 16'h0418));
        rr_tab.push_back(mk(1, 16'h0000, 0, 1, 3, 16'h0418));
        rr_tab.push_back(mk(1, 16'h0008, 1, 1, 4, 16'h0418));
        rr_tab.push_back(mk(1, 16'h0000, 1, 1, 10, 16'h0408));
        rr_tab.push_back(mk(1, 16'h0000, 1, 1, 3, 16'h0008));
        rr_tab.push_back(mk(1, 16'h0000, 1, 0, 0, 16'h0000));
        // no preemption, then reset mid-grant
        rr_tab.push_back(mk(1, 16'h0200, 0, 0, 0, 16'h0200));
        rr_tab.push_back(mk(1, 16'h0000, 0, 1, 9, 16'h0200));
        rr_tab.push_back(mk(1, 16'h0001, 0, 1, 9, 16'h0201));
        rr_tab.push_back(mk(1, 16'h0000, 0, 1, 9, 16'h0201));
        rr_tab.push_back(mk(0, 16'h0000, 0, 0, 0, 16'h0000));
        rr_tab.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000));

        // fixed priority: 2, 7, 8 then idle
        fx_tab.push_back(mk(0, 16'hFFFF, 0, 0, 0, 16'h0000));
        fx_tab.push_back(mk(1, 16'h0184, 0, 0, 0, 16'h0184));
        fx_tab.push_back(mk(1, 16'h0000, 1, 1, 2, 16'h0184));
        fx_tab.push_back(mk(1, 16'h0000, 1, 1, 7, 16'h0180));
        fx_tab.push_back(mk(1, 16'h0000, 1, 1, 8, 16'h0100));
        fx_tab.push_back(mk(1, 16'h0000, 1, 0, 0, 16'h0000));
        // no rotation: re-set bit 0 wins again over 15
        fx_tab.push_back(mk(1, 16'h8001, 0, 0, 0, 16'h8001));
        fx_tab.push_back(mk(1, 16'h0000, 1, 1, 0, 16'h8001));
        fx_tab.push_back(mk(1, 16'h8001, 1, 1, 0, 16'h8001));
        fx_tab.push_back(mk(1, 16'h0000, 1, 1, 15, 16'h8000));
        fx_tab.push_back(mk(1, 16'h0000, 1, 0, 0, 16'h0000));

        @(negedge CLK);
        foreach (rr_tab[k]) run_tab(0, rr_tab[k]);
        foreach (fx_tab[k]) run_tab(1, fx_tab[k]);

        // random traffic on both instances against the model
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 149) != 0);
            i0 = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom) : 16'h0;
            i1 = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom) : 16'h0;
            a0 = ($urandom_range(0, 9) < 6);
            a1 = ($urandom_range(0, 9) < 6);
            step(r, i0, a0, i1, a1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
